// File: rtl/mc_request_scheduler.sv
// mc_request_scheduler: in-order trace request queue that releases the head once the cycle counter reaches its timestamp
module mc_request_scheduler #(
  parameter int ADDR_WIDTH  = 36,
  parameter int MEMOP_WIDTH = 4,
  parameter int TIME_WIDTH  = 32,
  parameter int DEPTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [TIME_WIDTH-1:0]        in_time,
  input  logic [MEMOP_WIDTH-1:0]       in_op,
  input  logic [ADDR_WIDTH-1:0]        in_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MEMOP_WIDTH-1:0]       out_op,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic [TIME_WIDTH-1:0]        out_time,
  output logic [TIME_WIDTH-1:0]        cycle,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty,
  output logic                         op_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {EMPTY, WAIT, ISSUE} state_t;
  state_t state;
  logic [TIME_WIDTH-1:0]  mem_time [DEPTH];
  logic [MEMOP_WIDTH-1:0] mem_op   [DEPTH];
  logic [ADDR_WIDTH-1:0]  mem_addr [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [TIME_WIDTH-1:0] cycle_nxt, head_diff, next_diff;
  logic legal, offer, push, pop, head_due, next_due;
  assign full      = count == CW'(DEPTH);
  assign empty     = count == '0;
  assign in_ready  = !full;
  assign legal     = in_op <= MEMOP_WIDTH'(2);
  assign offer     = in_valid & in_ready;
  assign push      = offer & legal;
  assign pop       = out_valid & out_ready;
  assign rd_nxt    = rd_ptr + 1'b1;
  // Due is judged against the next cycle value so out_valid appears exactly when cycle equals the timestamp.
  assign cycle_nxt = cycle + TIME_WIDTH'(1);
  assign head_diff = cycle_nxt - mem_time[rd_ptr];
  assign next_diff = cycle_nxt - mem_time[rd_nxt];
  assign head_due  = !head_diff[TIME_WIDTH-1];
  assign next_due  = !next_diff[TIME_WIDTH-1];
  // Queue storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_time[wr_ptr] <= in_time;
      mem_op[wr_ptr]   <= in_op;
      mem_addr[wr_ptr] <= in_addr;
    end
  end
  // Cycle counter, pointers, occupancy and the issue FSM with registered head outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle     <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_op    <= '0;
      out_addr  <= '0;
      out_time  <= '0;
      op_err    <= 1'b0;
    end else begin
      cycle  <= cycle_nxt;
      op_err <= offer & !legal;
      count  <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_nxt;
      case (state)
        EMPTY: if (push) state <= WAIT;
        WAIT: if (head_due) begin
          state     <= ISSUE;
          out_valid <= 1'b1;
          out_op    <= mem_op[rd_ptr];
          out_addr  <= mem_addr[rd_ptr];
          out_time  <= mem_time[rd_ptr];
        end
        ISSUE: if (pop) begin
          if (count > CW'(1) && next_due) begin
            out_op   <= mem_op[rd_nxt];
            out_addr <= mem_addr[rd_nxt];
            out_time <= mem_time[rd_nxt];
          end else begin
            out_valid <= 1'b0;
            state     <= (count > CW'(1) || push) ? WAIT : EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_request_scheduler.sv
// tb_mc_request_scheduler: directed vector table plus hand sequences for timing, order, full, backpressure, error and wrap
module tb_mc_request_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_time = '0;
  logic [3:0] in_op = '0;
  logic [35:0] in_addr = '0;
  logic in_ready, out_valid, full, empty, op_err;
  logic [3:0] out_op;
  logic [35:0] out_addr;
  logic [31:0] out_time, cycle;
  logic [4:0] count;
  logic in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [7:0] in_time2 = '0;
  logic [35:0] in_addr2 = '0;
  logic in_ready2, out_valid2, full2, empty2, op_err2;
  logic [3:0] out_op2;
  logic [35:0] out_addr2;
  logic [7:0] out_time2, cycle2;
  logic [2:0] count2;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  mc_request_scheduler dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_time(in_time),
    .in_op(in_op), .in_addr(in_addr), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_addr(out_addr), .out_time(out_time), .cycle(cycle), .count(count), .full(full),
    .empty(empty), .op_err(op_err)
  );
  mc_request_scheduler #(.TIME_WIDTH(8), .DEPTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_time(in_time2),
    .in_op(4'd1), .in_addr(in_addr2), .out_valid(out_valid2), .out_ready(out_ready2), .out_op(out_op2),
    .out_addr(out_addr2), .out_time(out_time2), .cycle(cycle2), .count(count2), .full(full2),
    .empty(empty2), .op_err(op_err2)
  );
  typedef struct {
    logic v; logic [3:0] op; logic [31:0] t; logic [35:0] a; logic rdy;
    logic ov; logic [35:0] oa; logic [4:0] cnt; logic err;
  } vec_t;
  vec_t tbl [11];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cycle);
    end
  endtask
  task automatic push(input logic [31:0] t, input logic [3:0] op, input logic [35:0] a);
    in_valid = 1'b1; in_time = t; in_op = op; in_addr = a;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_cycle", cycle, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_op_err", op_err, 0);
    rst_n = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask
  initial begin
    int n;
    logic early, held;
    tbl[0]  = '{1'b1, 4'd1, 32'd0,  36'hA0, 1'b0, 1'b0, 36'h0,  5'd1, 1'b0};
    tbl[1]  = '{1'b1, 4'd2, 32'd2,  36'hA1, 1'b0, 1'b1, 36'hA0, 5'd2, 1'b0};
    tbl[2]  = '{1'b1, 4'd7, 32'd0,  36'hFF, 1'b0, 1'b1, 36'hA0, 5'd2, 1'b1};
    tbl[3]  = '{1'b0, 4'd0, 32'd0,  36'h0,  1'b1, 1'b1, 36'hA1, 5'd1, 1'b0};
    tbl[4]  = '{1'b1, 4'd0, 32'd10, 36'hA2, 1'b1, 1'b0, 36'h0,  5'd1, 1'b0};
    for (int i = 5; i < 9; i++) tbl[i] = '{1'b0, 4'd0, 32'd0, 36'h0, 1'b1, 1'b0, 36'h0, 5'd1, 1'b0};
    tbl[9]  = '{1'b0, 4'd0, 32'd0,  36'h0,  1'b1, 1'b1, 36'hA2, 5'd1, 1'b0};
    tbl[10] = '{1'b0, 4'd0, 32'd0,  36'h0,  1'b1, 1'b0, 36'h0,  5'd0, 1'b0};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      in_valid = tbl[i].v; in_op = tbl[i].op; in_time = tbl[i].t; in_addr = tbl[i].a; out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_cycle", i), cycle, 32'(i + 1));
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
      if (tbl[i].ov) chk($sformatf("vec%0d_out_addr", i), out_addr, tbl[i].oa);
      chk($sformatf("vec%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("vec%0d_empty", i), empty, tbl[i].cnt == 0);
      chk($sformatf("vec%0d_op_err", i), op_err, tbl[i].err);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    out_ready = 1'b1;
    push(32'd20, 4'd0, 36'h0_01FF_9700);
    early = 1'b0; n = 0;
    while (cycle != 32'd20 && n < 100) begin
      if (out_valid) early = 1'b1;
      tick(); n++;
    end
    chk("t2_early", early, 0);
    chk("t2_valid_at_20", out_valid, 1);
    chk("t2_addr", out_addr, 36'h0_01FF_9700);
    chk("t2_time", out_time, 20);
    chk("t2_op", out_op, 0);
    tick();
    chk("t2_popped", out_valid, 0);
    chk("t2_count", count, 0);
    push(32'd30, 4'd1, 36'hB0);
    push(32'd25, 4'd2, 36'hB1);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("t3_first_cycle", cycle, 30);
    chk("t3_first_addr", out_addr, 36'hB0);
    tick();
    chk("t3_second_valid", out_valid, 1);
    chk("t3_second_addr", out_addr, 36'hB1);
    chk("t3_second_cycle", cycle, 31);
    tick();
    chk("t3_drained", out_valid, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'd0, 4'd1, 36'hC0 + 36'(i));
    held = 1'b1;
    repeat (5) begin
      tick();
      if (!out_valid || out_addr != 36'hC0 || out_op != 4'd1) held = 1'b0;
    end
    chk("t5_held", held, 1);
    chk("t5_count", count, 4);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("t5_pop%0d_valid", i), out_valid, 1);
      chk($sformatf("t5_pop%0d_addr", i), out_addr, 36'hC0 + 36'(i));
    end
    tick();
    chk("t5_last_pop", out_valid, 0);
    chk("t5_empty", empty, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(32'd1000, 4'd0, 36'h100 + 36'(i));
    chk("t4_full", full, 1);
    chk("t4_in_ready", in_ready, 0);
    chk("t4_count", count, 16);
    in_valid = 1'b1; in_time = 32'd1000; in_addr = 36'h1FF;
    tick();
    chk("t4_held_off", count, 16);
    n = 0;
    while (!out_valid && n < 2000) begin tick(); n++; end
    chk("t4_head", out_addr, 36'h100);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_no_bypass", count, 15);
    chk("t4_ready_again", in_ready, 1);
    chk("t4_next_head", out_addr, 36'h101);
    do_reset();
    in_valid = 1'b1; in_op = 4'd3;
    tick();
    in_valid = 1'b0;
    chk("t6_err_op3", op_err, 1);
    chk("t6_cnt_op3", count, 0);
    tick();
    chk("t6_err_clear", op_err, 0);
    in_valid = 1'b1; in_op = 4'd7;
    tick();
    in_valid = 1'b0;
    chk("t6_err_op7", op_err, 1);
    chk("t6_cnt_op7", count, 0);
    tick();
    chk("t6_err_pulse", op_err, 0);
    n = 0;
    while (cycle2 != 8'd254 && n < 600) begin tick(); n++; end
    out_ready2 = 1'b1;
    in_valid2 = 1'b1; in_time2 = 8'd1; in_addr2 = 36'hD5;
    tick();
    in_valid2 = 1'b0;
    chk("wrap_c255", cycle2, 255);
    chk("wrap_count", count2, 1);
    chk("wrap_not_early", out_valid2, 0);
    tick();
    chk("wrap_c0", cycle2, 0);
    chk("wrap_not_at0", out_valid2, 0);
    tick();
    chk("wrap_issue_c1", out_valid2, 1);
    chk("wrap_addr", out_addr2, 36'hD5);
    tick();
    chk("wrap_popped", out_valid2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
